// File: rtl/slt_share_if.sv
// Request/response bundle between the two issue lanes and the shared compare unit.
// The master side issues requests and pipeline controls; the slave side is the arbiter.
interface slt_share_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 3
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_uns;
  logic [TAGW-1:0]  req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_uns;
  logic [TAGW-1:0]  req1_tag;

  logic             hold;
  logic             flush;

  logic             resp0_valid;
  logic             resp0_lt;
  logic             resp0_eq;
  logic [TAGW-1:0]  resp0_tag;
  logic             resp1_valid;
  logic             resp1_lt;
  logic             resp1_eq;
  logic [TAGW-1:0]  resp1_tag;

  modport master (
    output req0_valid, req0_a, req0_b, req0_uns, req0_tag,
    output req1_valid, req1_a, req1_b, req1_uns, req1_tag,
    output hold, flush,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_lt, resp0_eq, resp0_tag,
    input  resp1_valid, resp1_lt, resp1_eq, resp1_tag
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_uns, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_uns, req1_tag,
    input  hold, flush,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_lt, resp0_eq, resp0_tag,
    output resp1_valid, resp1_lt, resp1_eq, resp1_tag
  );
endinterface

// File: rtl/slt_share_arbiter.sv
// Round-robin shared less-than/equal compare unit for two issue lanes.
// Stage 1 captures the granted request, stage 2 registers the compare result.
module slt_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 3
) (
  input logic        clk,
  input logic        rst,
  slt_share_if.slave bus
);
  logic             ptr;  // lane that wins when both request
  logic             blocked;
  logic             gnt0;
  logic             gnt1;
  logic             accept;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_uns;
  logic [TAGW-1:0]  s1_tag;
  logic             s1_lane;

  logic             s2_valid;
  logic             s2_lt;
  logic             s2_eq;
  logic [TAGW-1:0]  s2_tag;
  logic             s2_lane;

  logic [WIDTH:0]   diff;
  logic             lt_c;
  logic             eq_c;

  always_comb begin
    blocked = rst | bus.hold | bus.flush;
    gnt0    = bus.req0_valid & (~bus.req1_valid | ~ptr);
    gnt1    = bus.req1_valid & (~bus.req0_valid |  ptr);
  end

  assign bus.req0_ready = gnt0 & ~blocked;
  assign bus.req1_ready = gnt1 & ~blocked;
  assign accept         = bus.req0_ready | bus.req1_ready;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    diff = {1'b0, s1_a} - {1'b0, s1_b};
    eq_c = (s1_a == s1_b);
    lt_c = diff[WIDTH];
    if (!s1_uns) begin
      lt_c = (s1_a[WIDTH-1] & ~s1_b[WIDTH-1]) |
             (~(s1_a[WIDTH-1] ^ s1_b[WIDTH-1]) & diff[WIDTH-1]);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_uns   <= 1'b0;
      s1_tag   <= '0;
      s1_lane  <= 1'b0;
      s2_valid <= 1'b0;
      s2_lt    <= 1'b0;
      s2_eq    <= 1'b0;
      s2_tag   <= '0;
      s2_lane  <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!bus.hold) begin
      s1_valid <= accept;
      if (accept) begin
        ptr     <= bus.req1_ready ? 1'b0 : 1'b1;
        s1_a    <= bus.req1_ready ? bus.req1_a   : bus.req0_a;
        s1_b    <= bus.req1_ready ? bus.req1_b   : bus.req0_b;
        s1_uns  <= bus.req1_ready ? bus.req1_uns : bus.req0_uns;
        s1_tag  <= bus.req1_ready ? bus.req1_tag : bus.req0_tag;
        s1_lane <= bus.req1_ready;
      end
      s2_valid <= s1_valid;
      s2_lt    <= lt_c;
      s2_eq    <= eq_c;
      s2_tag   <= s1_tag;
      s2_lane  <= s1_lane;
    end
  end

  assign bus.resp0_valid = s2_valid & ~s2_lane;
  assign bus.resp1_valid = s2_valid &  s2_lane;
  assign bus.resp0_lt    = s2_lt;
  assign bus.resp0_eq    = s2_eq;
  assign bus.resp0_tag   = s2_tag;
  assign bus.resp1_lt    = s2_lt;
  assign bus.resp1_eq    = s2_eq;
  assign bus.resp1_tag   = s2_tag;
endmodule

// File: tb/tb_slt_share_arbiter.sv
// Directed scoreboard bench for slt_share_arbiter: stimulus pushes expected responses,
// an independent monitor pops and compares them as the DUT presents results.
module tb_slt_share_arbiter;
  typedef struct {
    logic       lane;
    logic       lt;
    logic       eq;
    logic [2:0] tag;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  slt_share_if #(.WIDTH(32), .TAGW(3)) bus ();

  slt_share_arbiter #(.WIDTH(32), .TAGW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  exp_t last;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   extra    = 0;
  bit   seen     = 0;
  bit   doomed   = 0;
  logic lt0, eq0, lt1, eq1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    if (!bus.hold || bus.flush) seen = 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic uns, input logic [2:0] tag, input logic lt, input logic eq);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
    bus.req0_uns = uns; bus.req0_tag = tag; lt0 = lt; eq0 = eq;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic uns, input logic [2:0] tag, input logic lt, input logic eq);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
    bus.req1_uns = uns; bus.req1_tag = tag; lt1 = lt; eq1 = eq;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Called just after a falling edge: checks readies, records accepted ops, advances one cycle.
  task automatic tick(input logic r0, input logic r1);
    exp_t e;
    #1;
    check("req0_ready", bus.req0_ready, r0);
    check("req1_ready", bus.req1_ready, r1);
    if (!doomed && bus.req0_valid && r0) begin
      e = '{lane: 1'b0, lt: lt0, eq: eq0, tag: bus.req0_tag, due: cyc + 2 + extra};
      exp_q.push_back(e);
    end
    if (!doomed && bus.req1_valid && r1) begin
      e = '{lane: 1'b1, lt: lt1, eq: eq1, tag: bus.req1_tag, due: cyc + 2 + extra};
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.resp0_valid || bus.resp1_valid)) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            check("resp_lane", {bus.resp1_valid, bus.resp0_valid}, e.lane ? 2'b10 : 2'b01);
            check("resp_lt", e.lane ? bus.resp1_lt : bus.resp0_lt, e.lt);
            check("resp_eq", e.lane ? bus.resp1_eq : bus.resp0_eq, e.eq);
            check("resp_tag", e.lane ? bus.resp1_tag : bus.resp0_tag, e.tag);
            check("resp_latency", cyc, e.due);
            last = e;
            seen = 1;
          end
        end else begin
          check("hold_stable",
                {bus.resp1_valid, bus.resp0_valid, bus.resp0_lt, bus.resp0_eq, bus.resp0_tag},
                {last.lane, ~last.lane, last.lt, last.eq, last.tag});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    set0(1, 1, 2, 0, 0, 1, 0);
    set1(1, 7, 7, 0, 1, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_resp", {bus.resp1_valid, bus.resp0_valid, bus.resp0_lt, bus.resp0_eq, bus.resp0_tag}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Contention from reset: grants alternate lane0, lane1, lane0, lane1.
    tick(1, 0);
    set0(1, 32'hFFFF_FFFF, 0, 0, 2, 1, 0);
    tick(0, 1);
    set1(1, 32'hFFFF_FFFF, 0, 1, 3, 0, 0);
    tick(1, 0);
    set0(1, 4, 4, 0, 4, 0, 1);
    tick(0, 1);
    idle();

    // Lane 0 alone, then signed/unsigned extremes back to back.
    set0(1, 5, 9, 0, 3, 1, 0);
    tick(1, 0);
    set0(0, 0, 0, 0, 0, 0, 0);
    set1(1, 32'h8000_0000, 1, 0, 4, 1, 0);
    tick(0, 1);
    set1(0, 0, 0, 0, 0, 0, 0);
    set0(1, 32'h8000_0000, 1, 1, 5, 0, 0);
    tick(1, 0);
    set0(0, 0, 0, 0, 0, 0, 0);
    set1(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6, 0, 1);
    tick(0, 1);
    set1(0, 0, 0, 0, 0, 0, 0);
    set0(1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 7, 1, 0);
    tick(1, 0);
    set0(1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0, 0);
    tick(1, 0);
    idle();
    repeat (3) tick(0, 0);

    // Hold: op in stage 1 frozen for 3 cycles, then result held for 2 more.
    extra = 3;
    set0(1, 3, 3, 1, 5, 0, 1);
    tick(1, 0);
    extra = 0;
    bus.hold = 1'b1;
    set1(1, 9, 9, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      check("hold_no_resp", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
    end
    bus.hold = 1'b0;
    idle();
    tick(0, 0);
    bus.hold = 1'b1;
    repeat (2) tick(0, 0);
    bus.hold = 1'b0;
    set0(1, 10, 11, 0, 6, 1, 0);
    set1(1, 11, 10, 0, 7, 0, 0);
    tick(0, 1);
    idle();
    repeat (3) tick(0, 0);

    // Flush: second op killed in stage 1; flush also beats hold.
    set0(1, 10, 20, 1, 1, 1, 0);
    tick(1, 0);
    set0(0, 0, 0, 0, 0, 0, 0);
    set1(1, 20, 10, 1, 2, 0, 0);
    doomed = 1;
    tick(0, 1);
    doomed = 0;
    bus.flush = 1'b1;
    set0(1, 1, 1, 0, 0, 0, 1);
    tick(0, 0);
    bus.flush = 1'b0;
    set1(0, 0, 0, 0, 0, 0, 0);
    set0(1, 2, 1, 0, 3, 0, 0);
    doomed = 1;
    tick(1, 0);
    doomed = 0;
    bus.hold = 1'b1;
    bus.flush = 1'b1;
    set1(1, 1, 2, 0, 4, 1, 0);
    tick(0, 0);
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    idle();
    repeat (3) tick(0, 0);
    set0(1, 6, 6, 1, 2, 0, 1);
    set1(1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 4, 1, 0);
    tick(0, 1);
    idle();
    repeat (3) tick(0, 0);

    // Async reset with one op visible and one in stage 1.
    set0(1, 0, 0, 0, 6, 0, 1);
    tick(1, 0);
    set0(1, 1, 0, 0, 7, 0, 0);
    doomed = 1;
    tick(1, 0);
    doomed = 0;
    #2;
    rst = 1'b1;
    set1(1, 2, 3, 1, 5, 1, 0);
    #1;
    check("rst_resp_drop", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
    check("rst_ready_mid", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    set0(1, 3, 2, 1, 0, 0, 0);
    tick(1, 0);
    idle();
    repeat (4) tick(0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
